rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 3-to-8 decoded resource select between 8 requesters.
- Each cycle, the winner's 3-bit index drives a 3x8 one-hot decode. That decode becomes the registered one-hot grant vector consumed by the downstream mux/enable network.
- Fairness: rotating priority pointer plus a bounded hold time, so no requester can starve the others.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant before forced re-arbitration; legal range 1..15.
- HOLD_W, 4, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; low forces release and idle.
- req  input  8  request vector; bit i = requester i.
- gnt  output  8  one-hot grant; all-zero when no grant.
- gnt_idx  output  3  binary index of the current grantee; holds last value when gnt_valid=0.
- gnt_valid  output  1  high while a grant is active.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0.
  - Priority pointer ptr=3'd0, hold_cnt=0, state=IDLE.
  - rst asserted mid-grant clears the grant at that same edge; req/en are ignored while rst=1.
- Outputs are registered.
- gnt = decode3x8(gnt_idx) AND {8{gnt_valid}}, so gnt is always one-hot or zero.
- Winner selection (combinational): search order is ptr, ptr+1, ... ptr+7 (mod 8). The first index with req[i]=1 wins.
- FSM states: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0: load gnt_idx=winner, set gnt_valid=1, hold_cnt=1, go to GRANT.
  - Otherwise stay in IDLE with gnt_valid=0.
  - Latency: request sampled at edge N, grant visible after edge N (one cycle).
- GRANT, release conditions, checked at each edge:
  - (a) req[gnt_idx]=0, or
  - (b) hold_cnt==MAX_HOLD, or
  - (c) en=0.
- On release:
  - ptr <= gnt_idx+1 (mod 8, wraps 7 to 0).
  - Winner search uses the updated ptr, with the current grantee's request included last in the search order.
  - Back-to-back handoff: if en=1 and a winner exists, load the new gnt_idx, keep gnt_valid=1, set hold_cnt=1, stay in GRANT. No idle bubble.
  - Otherwise clear gnt_valid and go to IDLE.
  - Condition (c) always goes to IDLE, regardless of requests.
- No release: hold_cnt <= hold_cnt+1; gnt unchanged.
- Sole requester whose hold expires is re-granted immediately. gnt stays continuously high and hold_cnt restarts at 1.
- A requester whose bit drops is released at the next edge, so the grant persists one cycle after the drop is visible.
- Simultaneous release and new requests are resolved in the same edge per the rules above.
- Requests arriving mid-grant do not preempt the current grantee.
- gnt_idx retains its last value in IDLE. Consumers must qualify with gnt_valid.

Decomposition:
- Shared header (`include file):
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Requester count N_REQ=8 and index width IDX_W=3.
- One natural sub-module: rr_priority_pick.
  - Combinational rotate-and-find-first.
  - Inputs: req[7:0], ptr[2:0]. Outputs: win_idx[2:0], win_valid.
  - Instantiated once.
  - The 3x8 grant decode stays inline as a continuous assignment.

Test Plan:
- Reset, then en=1, req=8'b0000_0001 -> after 1 edge: gnt=8'h01, gnt_idx=0, gnt_valid=1; after rst pulse: gnt=8'h00, ptr=0.
- en=1, req=8'hFF held, MAX_HOLD=4 -> gnt=01 for 4 cycles, then 02 ×4, 04 ×4 ... 80 ×4, then back to 01. No zero cycles between grants.
- req=8'b1000_0100; requester 2 drops req after its 2nd grant cycle -> gnt=04 for 3 cycles total, then 80 on the next cycle with no bubble. ptr=3 after handoff.
- en deasserted during the grant to index 5 -> gnt=00 and gnt_valid=0 after the next edge. Re-assert en with req=8'hFF -> grant goes to index 6.
- Only req[3]=1 held for 10 cycles, MAX_HOLD=4 -> gnt=08 continuously. hold_cnt sequence 1,2,3,4,1,2,3,4,1,2.
- req=8'h00 with en=1 for 5 cycles -> gnt=00, gnt_valid=0 throughout. rst asserted in the same cycle as a request -> no grant issued that edge.

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, state encoding and grant decode for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] decode3x8(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
    import rr_arbiter_8_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (output en, req, input gnt, gnt_idx, gnt_valid);
    modport slave  (input en, req, output gnt, gnt_idx, gnt_valid);

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotate-and-find-first: first set request at or after ptr, wrapping mod 8.
module rr_priority_pick
    import rr_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             win_valid_o
);

    logic [IDX_W-1:0] cand;

    // Scanning from the far end down lets the nearest-to-ptr hit overwrite later ones.
    always_comb begin
        win_idx_o   = ptr_i;
        win_valid_o = 1'b0;
        cand        = ptr_i;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                win_idx_o   = cand;
                win_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with bounded hold time and registered one-hot grant.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    rr_arbiter_8_if.slave   bus
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [IDX_W-1:0]  pick_ptr;
    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;
    logic              release_now;

    // On release the search starts just past the grantee, so the grantee is considered last.
    assign pick_ptr    = (state_q == ST_GRANT) ? idx_q + IDX_W'(1) : ptr_q;
    assign release_now = (state_q == ST_GRANT) &&
                         (!bus.en || !bus.req[idx_q] || hold_q == HOLD_W'(MAX_HOLD));

    rr_priority_pick u_pick (
        .req_i       (bus.req),
        .ptr_i       (pick_ptr),
        .win_idx_o   (win_idx),
        .win_valid_o (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (bus.en && win_valid) begin
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    hold_d  = HOLD_W'(1);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_d = idx_q + IDX_W'(1);
                    // Handoff without a bubble; losing en always drops to idle.
                    if (bus.en && win_valid) begin
                        idx_d  = win_idx;
                        hold_d = HOLD_W'(1);
                    end else begin
                        valid_d = 1'b0;
                        hold_d  = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.gnt       = decode3x8(idx_q) & {N_REQ{valid_q}};
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench: directed vector table, hold-rotation sequence and random traffic vs a reference model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;

    // Reference model state: who holds the grant, for how long, and where the search begins.
    bit   mValid;
    int   mIdx;
    int   mPtr;
    int   mHold;

    vec_t vecs[$];

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int firstFrom(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic modelStep(input logic r, input logic e, input logic [7:0] q);
        int w;
        if (r) begin
            mValid = 0; mIdx = 0; mPtr = 0; mHold = 0;
        end else if (!mValid) begin
            w = firstFrom(q, mPtr);
            if (e && w >= 0) begin
                mValid = 1; mIdx = w; mHold = 1;
            end
        end else if (!e || !q[mIdx] || mHold == MAX_HOLD) begin
            mPtr = (mIdx + 1) % 8;
            w = firstFrom(q, mPtr);
            if (e && w >= 0) begin
                mIdx = w; mHold = 1;
            end else begin
                mValid = 0; mHold = 0;
            end
        end else begin
            mHold = mHold + 1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] q);
        rst     = r;
        bus.en  = e;
        bus.req = q;
        @(posedge clk);
        modelStep(r, e, q);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expGnt,
                               input logic [2:0] expIdx, input logic expValid);
        nCompared++;
        if (bus.gnt !== expGnt || bus.gnt_idx !== expIdx || bus.gnt_valid !== expValid) begin
            nMismatched++;
            $display("[TB] FAIL %s: got gnt=%02h idx=%0d valid=%0b, want gnt=%02h idx=%0d valid=%0b",
                     name, bus.gnt, bus.gnt_idx, bus.gnt_valid, expGnt, expIdx, expValid);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] q,
                                input logic [7:0] g, input logic [2:0] i, input logic v);
        vec_t t;
        t.rst = r; t.en = e; t.req = q; t.gnt = g; t.idx = i; t.valid = v;
        return t;
    endfunction

    initial begin
        logic [7:0] gExp;
        logic       r;
        logic       e;
        logic [7:0] q;

        clk = 0; rst = 1; bus.en = 0; bus.req = '0;
        nCompared = 0; nMismatched = 0;
        mValid = 0; mIdx = 0; mPtr = 0; mHold = 0;

        // Single requester, then reset mid-grant.
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h01, 8'h01, 3'd0, 1));
        vecs.push_back(mk(1, 1, 8'h01, 8'h00, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h01, 8'h01, 3'd0, 1));
        // Requester 2 drops after three grant cycles, handoff to 7 with no bubble.
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h84, 8'h04, 3'd2, 1));
        vecs.push_back(mk(0, 1, 8'h84, 8'h04, 3'd2, 1));
        vecs.push_back(mk(0, 1, 8'h84, 8'h04, 3'd2, 1));
        vecs.push_back(mk(0, 1, 8'h80, 8'h80, 3'd7, 1));
        // en dropped while 5 holds the grant; next grant starts at 6.
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 8'h20, 3'd5, 1));
        vecs.push_back(mk(0, 0, 8'h20, 8'h00, 3'd5, 0));
        vecs.push_back(mk(0, 1, 8'hFF, 8'h40, 3'd6, 1));
        // Sole requester 3 across two hold expiries stays granted.
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 3'd0, 0));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 8'h08, 8'h08, 3'd3, 1));
        // No requests, then reset coinciding with a request.
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 3'd0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 8'h00, 8'h00, 3'd0, 0));
        vecs.push_back(mk(1, 1, 8'hFF, 8'h00, 3'd0, 0));
        vecs.push_back(mk(0, 1, 8'hFF, 8'h01, 3'd0, 1));

        $display("[TB] directed table: %0d vectors", vecs.size());
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].en, vecs[k].req);
            checkOutput($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].idx, vecs[k].valid);
        end

        // All requesting: each index holds for MAX_HOLD cycles in turn and wraps 7 -> 0.
        applyStimulus(1, 0, 8'h00);
        for (int c = 0; c < 8 * MAX_HOLD + 4; c++) begin
            applyStimulus(0, 1, 8'hFF);
            gExp = 8'h01 << ((c / MAX_HOLD) % 8);
            checkOutput($sformatf("rotate%0d", c), gExp, 3'((c / MAX_HOLD) % 8), 1'b1);
        end

        // Random traffic against the reference model.
        applyStimulus(1, 0, 8'h00);
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 11) != 0);
            q = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            applyStimulus(r, e, q);
            gExp = mValid ? (8'h01 << mIdx) : 8'h00;
            checkOutput($sformatf("rand%0d", c), gExp, 3'(mIdx), mValid);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
